// File: rtl/gb_cart_pkg.sv
// gb_cart_pkg: shared types and constants for the MBC1 cartridge mapper.
//   state_t      - access FSM states
//   RGN_*        - cartridge address region decodes
//   *_W / MEM_AW - external memory address field widths
package gb_cart_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam logic       RGN_REGS = 1'b0;
  localparam logic [1:0] RGN_ROM0 = 2'b00;
  localparam logic [1:0] RGN_ROMX = 2'b01;
  localparam logic [2:0] RGN_RAM  = 3'b101;
  localparam int MEM_AW     = 21;
  localparam int ROM_OFS_W  = 14;
  localparam int RAM_OFS_W  = 13;
  localparam int ROM_BANK_W = 6;
  localparam int RAM_BANK_W = 2;
  localparam int BANK_LO_W  = 5;
  localparam int BANK_HI_W  = 2;
endpackage

// File: rtl/mbc1_bank_regs.sv
// mbc1_bank_regs: MBC1 control registers and cartridge-to-memory address translation.
//   clk, reset - clock, synchronous active-high reset
//   we         - register write strobe (one cycle per cart_wr rise)
//   wr_sel     - cart_addr[14:13] of the register write
//   wr_data    - cart_di[4:0] of the register write
//   addr       - cartridge address to translate
//   ram_en     - external RAM enable register
//   mem_addr   - translated external memory byte address
module mbc1_bank_regs
  import gb_cart_pkg::*;
#(
  parameter int ROM_BANKS_LOG2 = 6,
  parameter int RAM_BANKS_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        wr_sel,
  input  logic [4:0]        wr_data,
  input  logic [15:0]       addr,
  output logic              ram_en,
  output logic [MEM_AW-1:0] mem_addr
);
  localparam logic [6:0] ROM_MASK = 7'((1 << ROM_BANKS_LOG2) - 1);
  localparam logic [1:0] RAM_MASK = 2'((1 << RAM_BANKS_LOG2) - 1);
  logic [BANK_LO_W-1:0] bank_lo, lo_eff;
  logic [BANK_HI_W-1:0] bank_hi;
  logic [RAM_BANK_W-1:0] ram_bank;
  logic [ROM_BANK_W-1:0] rom_bank;
  logic [6:0] rom_sel;
  logic mode;
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_lo <= 5'd1;
      bank_hi <= '0;
      mode    <= 1'b0;
      ram_en  <= 1'b0;
    end else if (we) begin
      case (wr_sel)
        2'd0:    ram_en  <= wr_data[3:0] == 4'hA;
        2'd1:    bank_lo <= wr_data;
        2'd2:    bank_hi <= wr_data[1:0];
        default: mode    <= wr_data[0];
      endcase
    end
  end
  // Bank 0 in the low field always reads as bank 1, so 20h/40h/60h alias to 21h/41h/61h.
  always_comb begin
    lo_eff   = bank_lo == '0 ? 5'd1 : bank_lo;
    rom_sel  = addr[15:14] == RGN_ROMX ? {bank_hi, lo_eff} : mode ? {bank_hi, 5'b0} : 7'd0;
    rom_bank = 6'(rom_sel & ROM_MASK);
    ram_bank = (mode ? bank_hi : 2'd0) & RAM_MASK;
    mem_addr = addr[15:13] == RGN_RAM ? {1'b1, 5'b0, ram_bank, addr[RAM_OFS_W-1:0]}
                                      : {1'b0, rom_bank, addr[ROM_OFS_W-1:0]};
  end
endmodule

// File: rtl/cart_mbc1.sv
// cart_mbc1: MBC1 cartridge mapper bridging cartridge strobes to a handshaked external memory.
//   clk, reset       - clock, synchronous active-high reset
//   cart_addr/rd/wr  - cartridge bus address and strobes
//   cart_di, cart_do - cartridge write data, registered read data
//   mem_addr/rd/wr   - external memory request (bit20: 0 ROM, 1 RAM)
//   mem_di, mem_do   - external write data, read data
//   mem_ack          - one-cycle completion of the outstanding request
//   busy             - external access outstanding
module cart_mbc1
  import gb_cart_pkg::*;
#(
  parameter int ROM_BANKS_LOG2 = 6,
  parameter int RAM_BANKS_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cart_addr,
  input  logic              cart_rd,
  input  logic              cart_wr,
  input  logic [7:0]        cart_di,
  output logic [7:0]        cart_do,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_di,
  input  logic [7:0]        mem_do,
  input  logic              mem_ack,
  output logic              busy
);
  state_t state;
  logic wr_q, rd_q, pend_v, last_v, ram_en, rise, ram_rgn, wr_ram, rd_go;
  logic [15:0] pend_addr, last_addr, xaddr;
  logic [7:0] pend_data;
  logic [MEM_AW-1:0] xmem;
  assign rise    = cart_wr & ~wr_q;
  assign ram_rgn = cart_addr[15:13] == RGN_RAM;
  assign wr_ram  = rise & ram_rgn & ram_en;
  // A held read is re-serviced only when the strobe is new or the address moved.
  assign rd_go   = cart_rd & (cart_addr[15] == RGN_REGS | ram_rgn)
                 & (~rd_q | ~last_v | cart_addr != last_addr);
  assign xaddr   = pend_v ? pend_addr : cart_addr;
  mbc1_bank_regs #(.ROM_BANKS_LOG2(ROM_BANKS_LOG2), .RAM_BANKS_LOG2(RAM_BANKS_LOG2)) u_regs (
    .clk(clk),
    .reset(reset),
    .we(rise & cart_addr[15] == RGN_REGS),
    .wr_sel(cart_addr[14:13]),
    .wr_data(cart_di[4:0]),
    .addr(xaddr),
    .ram_en(ram_en),
    .mem_addr(xmem)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cart_do   <= 8'hFF;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_di    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      last_v    <= 1'b0;
      last_addr <= '0;
    end else begin
      wr_q <= cart_wr;
      rd_q <= cart_rd;
      if (state == IDLE) begin
        if (pend_v || wr_ram) begin
          state    <= WRITE;
          busy     <= 1'b1;
          mem_wr   <= 1'b1;
          mem_addr <= xmem;
          mem_di   <= pend_v ? pend_data : cart_di;
          pend_v   <= pend_v & wr_ram;
        end else if (rd_go) begin
          last_addr <= cart_addr;
          if (ram_rgn && !ram_en) begin
            cart_do <= 8'hFF;
            last_v  <= 1'b1;
          end else begin
            state    <= READ;
            busy     <= 1'b1;
            mem_rd   <= 1'b1;
            mem_addr <= xmem;
            last_v   <= 1'b0;
          end
        end
      end else begin
        if (wr_ram) pend_v <= 1'b1;
        if (mem_ack) begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          if (state == READ) begin
            cart_do <= mem_do;
            last_v  <= 1'b1;
          end
        end
      end
      if (wr_ram) begin
        pend_addr <= cart_addr;
        pend_data <= cart_di;
      end
    end
  end
endmodule

// File: tb/tb_cart_mbc1.sv
// tb_cart_mbc1: self-checking bench for cart_mbc1 (1 MB and 256 KB ROM instances in lockstep).
module tb_cart_mbc1;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] cart_addr = '0;
  logic cart_rd = 1'b0, cart_wr = 1'b0, mem_ack = 1'b0;
  logic [7:0] cart_di = '0, mem_do = '0;
  logic [7:0] cart_do, mem_di, cart_do4, mem_di4;
  logic [20:0] mem_addr, mem_addr4;
  logic mem_rd, mem_wr, busy, mem_rd4, mem_wr4, busy4;
  int total = 0, bad = 0, overlap = 0;

  cart_mbc1 #(.ROM_BANKS_LOG2(6), .RAM_BANKS_LOG2(2)) dut (
    .clk(clk), .reset(reset), .cart_addr(cart_addr), .cart_rd(cart_rd), .cart_wr(cart_wr),
    .cart_di(cart_di), .cart_do(cart_do), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_di(mem_di), .mem_do(mem_do), .mem_ack(mem_ack), .busy(busy)
  );
  cart_mbc1 #(.ROM_BANKS_LOG2(4), .RAM_BANKS_LOG2(2)) dut4 (
    .clk(clk), .reset(reset), .cart_addr(cart_addr), .cart_rd(cart_rd), .cart_wr(cart_wr),
    .cart_di(cart_di), .cart_do(cart_do4), .mem_addr(mem_addr4), .mem_rd(mem_rd4), .mem_wr(mem_wr4),
    .mem_di(mem_di4), .mem_do(mem_do), .mem_ack(mem_ack), .busy(busy4)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (mem_rd && mem_wr) overlap++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [15:0] a, input logic [7:0] d);
    cart_addr = a;
    cart_di = d;
    cart_wr = 1'b1;
    step;
    cart_wr = 1'b0;
    step;
  endtask

  // Start a read, hold it dly cycles past issue, then ack with d.
  task automatic do_read(input logic [15:0] a, input int dly, input logic [7:0] d,
                         output logic [20:0] ma, output logic [20:0] ma4, output int n,
                         output logic iss);
    cart_addr = a;
    cart_rd = 1'b1;
    step;
    iss = mem_rd;
    ma = mem_addr;
    ma4 = mem_addr4;
    n = 0;
    if (iss) begin
      n = 1;
      repeat (dly) begin
        step;
        n += int'(mem_rd);
      end
      mem_do = d;
      mem_ack = 1'b1;
      step;
      mem_ack = 1'b0;
    end
    cart_rd = 1'b0;
    step;
  endtask

  // Reference address from the mapping rules as plain arithmetic.
  function automatic logic [20:0] ref_addr(int a, int lo, int hi, int md, int log2);
    int b, l;
    l = lo % 32;
    if (l == 0) l = 1;
    hi = hi % 4;
    md = md % 2;
    if (a >= 'hA000) return 21'('h100000 + (md != 0 ? hi : 0) * 'h2000 + a % 'h2000);
    b = (a < 'h4000) ? (md != 0 ? hi * 32 : 0) : hi * 32 + l;
    b = b % (1 << log2);
    return 21'(b * 'h4000 + a % 'h4000);
  endfunction

  typedef struct {
    logic [7:0] lo, hi, mode;
    logic [15:0] addr;
    logic [20:0] exp, exp4;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic [20:0] ma, ma4, ea;
    logic [7:0] lo, hi, md, en, d;
    logic [15:0] a;
    logic iss, exp_iss;
    int n, r;
    tbl[0] = '{8'h00, 8'h00, 8'h00, 16'h4000, 21'h004000, 21'h004000};
    tbl[1] = '{8'h20, 8'h00, 8'h00, 16'h4001, 21'h004001, 21'h004001};
    tbl[2] = '{8'h01, 8'h01, 8'h01, 16'h0010, 21'h080010, 21'h000010};
    tbl[3] = '{8'h05, 8'h01, 8'h00, 16'h0010, 21'h000010, 21'h000010};
    tbl[4] = '{8'h00, 8'h02, 8'h00, 16'h7FFF, 21'h007FFF, 21'h007FFF};
    tbl[5] = '{8'h1F, 8'h00, 8'h01, 16'h5ABC, 21'h07DABC, 21'h03DABC};
    tbl[6] = '{8'h03, 8'h03, 8'h01, 16'h3FFF, 21'h083FFF, 21'h003FFF};
    tbl[7] = '{8'h01, 8'h02, 8'h01, 16'hA005, 21'h104005, 21'h104005};
    tbl[8] = '{8'h01, 8'h03, 8'h00, 16'hBFFF, 21'h101FFF, 21'h101FFF};
    tbl[9] = '{8'h01, 8'h03, 8'h01, 16'hB000, 21'h107000, 21'h107000};

    repeat (3) step;
    reset = 1'b0;
    step;
    chk("rst_cart_do", cart_do, 8'hFF);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_di", mem_di, 0);
    chk("rst_busy", busy, 0);

    do_read(16'h4123, 3, 8'hC3, ma, ma4, n, iss);
    chk("s1_issued", iss, 1);
    chk("s1_addr", ma, 21'h004123);
    chk("s1_rd_cycles", n, 4);
    chk("s1_data", cart_do, 8'hC3);
    chk("s1_busy", busy, 0);

    cart_addr = 16'h4123;
    cart_rd = 1'b1;
    step;
    chk("hold_issue", mem_rd, 1);
    mem_do = 8'h5E;
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    n = 0;
    repeat (4) begin
      step;
      n += int'(mem_rd);
    end
    chk("hold_no_reread", n, 0);
    chk("hold_data", cart_do, 8'h5E);
    cart_addr = 16'h4124;
    step;
    chk("addr_change_reread", mem_rd, 1);
    chk("addr_change_addr", mem_addr, 21'h004124);
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    cart_rd = 1'b0;
    step;

    do_read(16'hA005, 0, 8'h00, ma, ma4, n, iss);
    chk("ramoff_rd_issued", iss, 0);
    chk("ramoff_rd_data", cart_do, 8'hFF);

    cart_addr = 16'hA001;
    cart_di = 8'h11;
    cart_wr = 1'b1;
    step;
    chk("ramoff_wr_ignored", mem_wr, 0);
    cart_wr = 1'b0;
    step;
    chk("ramoff_wr_busy", busy, 0);

    reg_wr(16'h0000, 8'h0A);
    reg_wr(16'h4000, 8'h02);
    reg_wr(16'h6000, 8'h01);
    cart_addr = 16'hA005;
    cart_di = 8'h5A;
    cart_wr = 1'b1;
    step;
    chk("ramwr_mem_wr", mem_wr, 1);
    chk("ramwr_addr", mem_addr, 21'h104005);
    chk("ramwr_di", mem_di, 8'h5A);
    chk("ramwr_busy", busy, 1);
    cart_wr = 1'b0;
    step;
    chk("ramwr_held", mem_wr, 1);
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    chk("ramwr_drop", mem_wr, 0);
    chk("ramwr_idle", busy, 0);

    for (int i = 0; i < 10; i++) begin
      reg_wr(16'h2000, tbl[i].lo);
      reg_wr(16'h4000, tbl[i].hi);
      reg_wr(16'h6000, tbl[i].mode);
      do_read(tbl[i].addr, i % 3, 8'h10 + 8'(i), ma, ma4, n, iss);
      chk($sformatf("tbl%0d_issued", i), iss, 1);
      chk($sformatf("tbl%0d_addr", i), ma, tbl[i].exp);
      chk($sformatf("tbl%0d_addr_rom16", i), ma4, tbl[i].exp4);
      chk($sformatf("tbl%0d_data", i), cart_do, 8'h10 + 8'(i));
    end

    reg_wr(16'h0000, 8'h0A);
    reg_wr(16'h4000, 8'h00);
    reg_wr(16'h6000, 8'h00);
    cart_addr = 16'h4000;
    cart_rd = 1'b1;
    step;
    chk("wdr_rd_issued", mem_rd, 1);
    cart_rd = 1'b0;
    cart_addr = 16'hA000;
    cart_di = 8'h77;
    cart_wr = 1'b1;
    step;
    cart_wr = 1'b0;
    chk("wdr_wr_deferred", mem_wr, 0);
    repeat (3) step;
    chk("wdr_rd_still", mem_rd, 1);
    mem_do = 8'h21;
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    chk("wdr_rd_drop", mem_rd, 0);
    chk("wdr_wr_not_yet", mem_wr, 0);
    chk("wdr_rd_data", cart_do, 8'h21);
    step;
    chk("wdr_wr_issued", mem_wr, 1);
    chk("wdr_wr_addr", mem_addr, 21'h100000);
    chk("wdr_wr_di", mem_di, 8'h77);
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    n = 0;
    repeat (6) begin
      step;
      n += int'(mem_wr);
    end
    chk("wdr_wr_once", n, 0);
    chk("wdr_idle", busy, 0);

    for (int i = 0; i < 40; i++) begin
      lo = 8'($urandom);
      hi = 8'($urandom);
      md = 8'($urandom);
      en = $urandom_range(0, 1) != 0 ? {4'($urandom), 4'hA} : 8'($urandom);
      r = $urandom_range(0, 2);
      a = r == 0 ? 16'($urandom_range(0, 'h3FFF)) :
          r == 1 ? 16'($urandom_range('h4000, 'h7FFF)) : 16'($urandom_range('hA000, 'hBFFF));
      d = 8'($urandom_range(0, 254));
      reg_wr(16'h0000, en);
      reg_wr(16'h2000, lo);
      reg_wr(16'h4000, hi);
      reg_wr(16'h6000, md);
      do_read(a, $urandom_range(0, 3), d, ma, ma4, n, iss);
      exp_iss = !(int'(a) >= 'hA000 && en[3:0] != 4'hA);
      chk($sformatf("rnd%0d_issued a=%h", i, a), iss, exp_iss);
      if (exp_iss) begin
        ea = ref_addr(int'(a), int'(lo), int'(hi), int'(md), 6);
        chk($sformatf("rnd%0d_addr", i), ma, ea);
        ea = ref_addr(int'(a), int'(lo), int'(hi), int'(md), 4);
        chk($sformatf("rnd%0d_addr_rom16", i), ma4, ea);
        chk($sformatf("rnd%0d_data", i), cart_do, d);
      end else begin
        chk($sformatf("rnd%0d_ramoff", i), cart_do, 8'hFF);
      end
    end

    cart_addr = 16'h4100;
    cart_rd = 1'b1;
    step;
    chk("rst_mid_issued", mem_rd, 1);
    step;
    reset = 1'b1;
    cart_rd = 1'b0;
    step;
    reset = 1'b0;
    mem_do = 8'h33;
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    step;
    chk("rst_mid_mem_rd", mem_rd, 0);
    chk("rst_mid_mem_wr", mem_wr, 0);
    chk("rst_mid_cart_do", cart_do, 8'hFF);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);

    chk("rd_wr_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
